// File: rtl/apx_add_sched_pkg.sv
// Shared types and defaults for the approximate-adder scheduler.
package apx_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECONFIG,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam int DEF_ADD_LATENCY   = 1;
    localparam int DEF_SWITCH_CYCLES = 2;
    localparam int CNT_W             = 8;
    localparam int SW_CNT_W          = 16;

    function automatic logic [SW_CNT_W-1:0] sat_inc(input logic [SW_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/apx_add_sched_if.sv
// Request, adder and response bundle between requesters and the adder scheduler.
interface apx_add_sched_if
    import apx_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DW      = 32,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*DW-1:0] req_a;
    logic [NUM_REQ*DW-1:0] req_b;
    logic [NUM_REQ-1:0]    req_exact;
    logic                  add_reg_en;
    logic [DW-1:0]         add_a;
    logic [DW-1:0]         add_b;
    logic [DW-1:0]         add_c;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DW-1:0]         rsp_data;
    logic [ID_W-1:0]       rsp_id;
    logic                  rsp_exact;
    logic                  busy;
    logic [SW_CNT_W-1:0]   switch_cnt;

    modport slave (
        input  req_valid, req_a, req_b, req_exact, add_c, rsp_ready,
        output req_ready, add_reg_en, add_a, add_b, rsp_valid, rsp_data,
               rsp_id, rsp_exact, busy, switch_cnt
    );

    modport master (
        output req_valid, req_a, req_b, req_exact, add_c, rsp_ready,
        input  req_ready, add_reg_en, add_a, add_b, rsp_valid, rsp_data,
               rsp_id, rsp_exact, busy, switch_cnt
    );
endinterface

// File: rtl/apx_add_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or after the pointer.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);
    logic [ID_W-1:0] w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_j = ID_W'((int'(i_ptr) + k) % NUM_REQ);
            if (!o_any && i_valid[w_j]) begin
                o_any      = 1'b1;
                o_idx      = w_j;
                o_grant[w_j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/apx_add_sched.sv
// Shares one clock-gated approximate adder among NUM_REQ requesters:
// round-robin grant, gating reconfiguration with settle time, tagged response.
//
// state      | meaning
// S_IDLE     | arbitrate, accept one request
// S_RECONFIG | add_reg_en changed, wait SWITCH_CYCLES for gating to settle
// S_ISSUE    | register operands onto the adder inputs
// S_WAIT     | count down ADD_LATENCY, capture add_c on the last cycle
// S_RESP     | hold the response until the consumer accepts
module apx_add_sched
    import apx_sched_pkg::*;
#(
    parameter int NUM_REQ            = 4,
    parameter int DATA_PATH_BITWIDTH = 32,
    parameter int ADD_LATENCY        = DEF_ADD_LATENCY,
    parameter int SWITCH_CYCLES      = DEF_SWITCH_CYCLES,
    parameter int ID_W               = $clog2(NUM_REQ)
) (
    input  logic           clk,
    input  logic           rst,
    apx_add_sched_if.slave bus
);
    localparam int DW = DATA_PATH_BITWIDTH;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [CNT_W-1:0]    r_cnt;
    logic [DW-1:0]       r_lat_a;
    logic [DW-1:0]       r_lat_b;
    logic                r_lat_exact;
    logic [ID_W-1:0]     r_lat_id;
    logic                r_add_reg_en;
    logic [DW-1:0]       r_add_a;
    logic [DW-1:0]       r_add_b;
    logic                r_rsp_valid;
    logic [DW-1:0]       r_rsp_data;
    logic [ID_W-1:0]     r_rsp_id;
    logic                r_rsp_exact;
    logic [SW_CNT_W-1:0] r_switch_cnt;

    logic [NUM_REQ-1:0]  w_grant;
    logic [ID_W-1:0]     w_idx;
    logic                w_any;
    logic                w_xfer;
    logic                w_req_exact;
    logic                w_mode_change;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .i_valid (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_xfer        = (r_state == S_IDLE) && w_any;
    assign w_req_exact   = bus.req_exact[w_idx];
    assign w_mode_change = (w_req_exact != r_add_reg_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_any) w_state_nxt = w_mode_change ? S_RECONFIG : S_ISSUE;
            S_RECONFIG: if (r_cnt == CNT_W'(1)) w_state_nxt = S_ISSUE;
            S_ISSUE:    w_state_nxt = S_WAIT;
            S_WAIT:     if (r_cnt == CNT_W'(1)) w_state_nxt = S_RESP;
            S_RESP:     if (bus.rsp_ready) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr     <= '0;
            r_cnt        <= '0;
            r_lat_a      <= '0;
            r_lat_b      <= '0;
            r_lat_exact  <= 1'b0;
            r_lat_id     <= '0;
            r_add_reg_en <= 1'b1;
            r_add_a      <= '0;
            r_add_b      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_id     <= '0;
            r_rsp_exact  <= 1'b0;
            r_switch_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_xfer) begin
                    r_lat_a     <= bus.req_a[int'(w_idx)*DW +: DW];
                    r_lat_b     <= bus.req_b[int'(w_idx)*DW +: DW];
                    r_lat_exact <= w_req_exact;
                    r_lat_id    <= w_idx;
                    r_rr_ptr    <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
                    // Gating changes on RECONFIG entry so the settle window starts immediately
                    if (w_mode_change) begin
                        r_add_reg_en <= w_req_exact;
                        r_switch_cnt <= sat_inc(r_switch_cnt);
                        r_cnt        <= CNT_W'(SWITCH_CYCLES);
                    end
                end
                S_RECONFIG: r_cnt <= r_cnt - 1'b1;
                S_ISSUE: begin
                    r_add_a <= r_lat_a;
                    r_add_b <= r_lat_b;
                    r_cnt   <= CNT_W'(ADD_LATENCY);
                end
                S_WAIT: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_rsp_data  <= bus.add_c;
                        r_rsp_id    <= r_lat_id;
                        r_rsp_exact <= r_lat_exact;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: if (bus.rsp_ready) r_rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE) ? w_grant : '0;
    assign bus.add_reg_en = r_add_reg_en;
    assign bus.add_a      = r_add_a;
    assign bus.add_b      = r_add_b;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_exact  = r_rsp_exact;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.switch_cnt = r_switch_cnt;
endmodule

// File: tb/tb_apx_add_sched.sv
// Directed self-checking bench for apx_add_sched with a behavioural gated adder.
module tb_apx_add_sched;
    import apx_sched_pkg::*;

    localparam int NR  = 4;
    localparam int DW  = 32;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    apx_add_sched_if #(.NUM_REQ(NR), .DW(DW), .ID_W(IDW)) bus();

    apx_add_sched #(
        .NUM_REQ(NR), .DATA_PATH_BITWIDTH(DW), .ADD_LATENCY(1),
        .SWITCH_CYCLES(2), .ID_W(IDW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Approximate mode: the low 16 bits are gated off (read as zero, no carry out of them)
    always_comb begin
        if (bus.add_reg_en) bus.add_c = bus.add_a + bus.add_b;
        else                bus.add_c = {bus.add_a[31:16] + bus.add_b[31:16], 16'h0000};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Presents one request from IDLE and returns cycles from presentation to rsp_valid
    task automatic issue_one(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] b,
                             input logic ex, output int cyc);
        logic [NR-1:0] sel;
        sel = '0;
        sel[idx] = 1'b1;
        bus.req_a[int'(idx)*DW +: DW] = a;
        bus.req_b[int'(idx)*DW +: DW] = b;
        bus.req_exact[idx] = ex;
        bus.req_valid = sel;
        #1;
        chk("req_ready", 32'(bus.req_ready), 32'(sel));
        tick();
        bus.req_valid = '0;
        cyc = 1;
        while (!bus.rsp_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        if (!bus.rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && bus.req_ready != '0)
            chk("ready_gnt", 32'({~$onehot0(bus.req_ready), |(bus.req_ready & ~bus.req_valid)}), 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int got;
        int seen;

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_exact = '1;
        bus.rsp_ready = 1'b1;
        tick();
        chk("rst_reg_en",  32'(bus.add_reg_en), 32'd1);
        chk("rst_valid",   32'(bus.rsp_valid),  32'd0);
        chk("rst_busy",    32'(bus.busy),       32'd0);
        chk("rst_swcnt",   32'(bus.switch_cnt), 32'd0);
        chk("rst_add_a",   bus.add_a,           32'd0);
        tick();
        rst = 1'b0;

        // single exact request, no reconfiguration
        issue_one(2'd0, 32'd5, 32'd7, 1'b1, cyc);
        chk("t1_lat",   32'(cyc),            32'd3);
        chk("t1_data",  bus.rsp_data,        32'd12);
        chk("t1_id",    32'(bus.rsp_id),     32'd0);
        chk("t1_exact", 32'(bus.rsp_exact),  32'd1);
        chk("t1_swcnt", 32'(bus.switch_cnt), 32'd0);
        tick();
        chk("t1_idle",  32'(bus.busy),       32'd0);
        chk("t1_vlow",  32'(bus.rsp_valid),  32'd0);

        // mode switch to approximate
        do_reset();
        bus.req_a[2*DW +: DW] = 32'h0001_FFFF;
        bus.req_b[2*DW +: DW] = 32'd1;
        bus.req_exact[2]      = 1'b0;
        bus.req_valid         = 4'b0100;
        #1;
        chk("t2_ready", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = '0;
        chk("t2_reg_en", 32'(bus.add_reg_en), 32'd0);
        chk("t2_swcnt",  32'(bus.switch_cnt), 32'd1);
        chk("t2_busy",   32'(bus.busy),       32'd1);
        tick();
        tick();
        chk("t2_a_hold", bus.add_a, 32'd0);
        tick();
        chk("t2_add_a",  bus.add_a, 32'h0001_FFFF);
        chk("t2_add_b",  bus.add_b, 32'd1);
        tick();
        chk("t2_valid",  32'(bus.rsp_valid), 32'd1);
        chk("t2_data",   bus.rsp_data,       32'h0001_0000);
        chk("t2_id",     32'(bus.rsp_id),    32'd2);
        chk("t2_exact",  32'(bus.rsp_exact), 32'd0);
        tick();
        chk("t2_idle",   32'(bus.busy),      32'd0);

        // round robin with all requesters continuously valid
        do_reset();
        for (int i = 0; i < NR; i++) begin
            bus.req_a[i*DW +: DW] = 32'(100 + i);
            bus.req_b[i*DW +: DW] = 32'(1000 * i);
        end
        bus.req_exact = '1;
        bus.req_valid = 4'hF;
        got = 0;
        cyc = 0;
        while (got < 6 && cyc < 80) begin
            tick();
            cyc++;
            if (bus.rsp_valid) begin
                chk("rr_id",   32'(bus.rsp_id), 32'(got % 4));
                chk("rr_data", bus.rsp_data,    32'(100 + 1001 * (got % 4)));
                got++;
            end
        end
        if (got < 6) chk("rr_count", 32'(got), 32'd6);
        bus.req_valid = '0;
        tick();
        chk("rr_idle", 32'(bus.busy), 32'd0);

        // backpressure: consumer stalls for 10 cycles
        bus.rsp_ready = 1'b0;
        issue_one(2'd3, 32'hFFFF_FFFF, 32'd2, 1'b1, cyc);
        chk("bp_lat",  32'(cyc),         32'd3);
        chk("bp_data", bus.rsp_data,     32'd1);
        chk("bp_id",   32'(bus.rsp_id),  32'd3);
        bus.req_valid = 4'b0011;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_hold",  bus.rsp_data,       32'd1);
            chk("bp_busy",  32'(bus.busy),      32'd1);
            chk("bp_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        tick();
        chk("bp_vlow", 32'(bus.rsp_valid), 32'd0);
        chk("bp_idle", 32'(bus.busy),      32'd0);

        // reset asserted during WAIT after a mode switch
        bus.req_a[1*DW +: DW] = 32'd3;
        bus.req_b[1*DW +: DW] = 32'd4;
        bus.req_exact[1]      = 1'b0;
        bus.req_valid         = 4'b0010;
        tick();
        bus.req_valid = '0;
        chk("mr_reg_en0", 32'(bus.add_reg_en), 32'd0);
        tick();
        tick();
        tick();
        chk("mr_wait_busy", 32'(bus.busy),      32'd1);
        chk("mr_wait_a",    bus.add_a,          32'd3);
        chk("mr_wait_vld",  32'(bus.rsp_valid), 32'd0);
        rst = 1'b1;
        #1;
        chk("mr_reg_en", 32'(bus.add_reg_en), 32'd1);
        chk("mr_add_a",  bus.add_a,           32'd0);
        chk("mr_busy",   32'(bus.busy),       32'd0);
        chk("mr_swcnt",  32'(bus.switch_cnt), 32'd0);
        chk("mr_data",   bus.rsp_data,        32'd0);
        chk("mr_id",     32'(bus.rsp_id),     32'd0);
        chk("mr_ready",  32'(bus.req_ready),  32'd0);
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.rsp_valid) seen++;
        end
        chk("mr_no_rsp", 32'(seen), 32'd0);

        // switch counter saturation from a preloaded value
        force dut.r_switch_cnt = 16'hFFFE;
        #2;
        release dut.r_switch_cnt;
        issue_one(2'd0, 32'h0003_0005, 32'h0001_0007, 1'b0, cyc);
        chk("sat_lat1",  32'(cyc),            32'd5);
        chk("sat_cnt1",  32'(bus.switch_cnt), 32'h0000_FFFF);
        chk("sat_data1", bus.rsp_data,        32'h0004_0000);
        tick();
        issue_one(2'd1, 32'h0003_0005, 32'h0001_0007, 1'b1, cyc);
        chk("sat_cnt2",  32'(bus.switch_cnt), 32'h0000_FFFF);
        chk("sat_data2", bus.rsp_data,        32'h0004_000C);
        chk("sat_exact", 32'(bus.rsp_exact),  32'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
